// File: rtl/cos_loss_pkg.sv
// Shared types and Q2.30 constants for the cosine-loss sequencer.
package cos_loss_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 30;

  localparam logic [Q_W-1:0] ONE_Q30     = 32'h4000_0000;
  localparam logic [Q_W-1:0] NEG_ONE_Q30 = 32'hC000_0000;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ISSUE,
    DRAIN,
    FIN,
    ACC,
    DONE
  } state_t;

  // 1 - clamp(cos, -1.0, +1.0); always in 0..0x8000_0000, so it fits 32 bits unsigned
  function automatic logic [Q_W-1:0] loss_term(input logic [Q_W-1:0] cos_val);
    logic signed [Q_W-1:0] c;
    c = $signed(cos_val);
    if (c > $signed(ONE_Q30))          c = $signed(ONE_Q30);
    else if (c < $signed(NEG_ONE_Q30)) c = $signed(NEG_ONE_Q30);
    return ONE_Q30 - $unsigned(c);
  endfunction

endpackage

// File: rtl/cos_loss_rd_track.sv
// Tracks granted reads through the fixed memory latency; the tail strobe is the
// MAC enable and an all-zero pipe means every issued read has been consumed.
module cos_loss_rd_track #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic mac_en,
  output logic pipe_empty
);

  logic [RD_LAT-1:0] pipe;

  // shift issue strobes toward the MAC; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mac_en     = pipe[RD_LAT-1];
  assign pipe_empty = ~|pipe;

endmodule

// File: rtl/cos_loss_seq_ctrl.sv
// Row sequencer for the cosine-similarity loss: issues operand reads, frames
// the MAC with clear/enable, hands each row to the cos unit, accumulates
// (1 - cos) and reports the mean over all rows.
// Handshakes: a read is issued in any cycle with mem_req && mem_gnt; while
// mem_req is high and mem_gnt low, mem_addr is held. fin_start is a one-cycle
// pulse and fin_done is a one-cycle pulse that is only honoured in FIN.
module cos_loss_seq_ctrl
  import cos_loss_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       cfg_len,
  input  logic [3:0]        cfg_log2_rows,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              fin_start,
  input  logic              fin_done,
  input  logic [31:0]       fin_cos,
  output logic              done,
  output logic              err,
  output logic [31:0]       loss_out,
  output state_t            dbg_state
);

  state_t            state, state_nxt;
  logic [15:0]       len_q, elem_cnt, row_cnt;
  logic [3:0]        lg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic [31:0]       cos_q, loss_q, loss_nxt;
  logic              err_q, fin_seen;
  logic              issue, last_elem, last_row, pipe_empty;

  assign issue     = mem_req & mem_gnt;
  assign last_elem = (elem_cnt == len_q - 16'd1);
  assign last_row  = (row_cnt == ((16'd1 << lg_q) - 16'd1));
  assign acc_sum   = acc_q + {{(ACC_W-32){1'b0}}, loss_term(cos_q)};
  assign loss_nxt  = 32'(acc_sum >> lg_q);

  cos_loss_rd_track #(.RD_LAT(RD_LAT)) u_rd_track (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .mac_en     (mac_en),
    .pipe_empty (pipe_empty)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic and Moore outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    mem_req   = (state == ISSUE);
    mac_clr   = (state == CLR);
    fin_start = (state == FIN) && !fin_seen;
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_len == 16'd0) ? DONE : CLR;
      CLR:     state_nxt = ISSUE;
      ISSUE:   if (issue && last_elem) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = FIN;
      FIN:     if (fin_done) state_nxt = ACC;
      ACC:     state_nxt = last_row ? DONE : CLR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // config latch, address/counter advance, cos capture and loss accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      lg_q     <= '0;
      addr_q   <= '0;
      elem_cnt <= '0;
      row_cnt  <= '0;
      acc_q    <= '0;
      cos_q    <= '0;
      loss_q   <= '0;
      err_q    <= 1'b0;
      fin_seen <= 1'b0;
    end else begin
      fin_seen <= (state == FIN);
      case (state)
        IDLE: if (start) begin
          len_q    <= cfg_len;
          lg_q     <= cfg_log2_rows;
          addr_q   <= cfg_base;
          elem_cnt <= '0;
          row_cnt  <= '0;
          acc_q    <= '0;
          err_q    <= (cfg_len == 16'd0);
          if (cfg_len == 16'd0) loss_q <= '0;
        end
        ISSUE: if (issue) begin
          addr_q   <= addr_q + ADDR_W'(1);
          elem_cnt <= last_elem ? 16'd0 : elem_cnt + 16'd1;
        end
        FIN: if (fin_done) cos_q <= fin_cos;
        ACC: begin
          acc_q   <= acc_sum;
          row_cnt <= row_cnt + 16'd1;
          if (last_row) loss_q <= loss_nxt;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign loss_out  = loss_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_cos_loss_seq_ctrl.sv
// Directed bench for the cosine-loss sequencer: each task runs one job
// scenario and checks the trace and result against hand-derived values.
module tb_cos_loss_seq_ctrl;
  import cos_loss_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, mem_gnt, fin_done;
  logic [15:0] cfg_len, cfg_base;
  logic [3:0]  cfg_log2_rows;
  logic [31:0] fin_cos;
  logic        busy, mem_req, mac_clr, mac_en, fin_start, done, err;
  logic [15:0] mem_addr;
  logic [31:0] loss_out;
  state_t      dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // job trace collected by run_job
  logic [15:0] addr_log[$];
  logic [15:0] exp_q[$];
  int          issue_cyc[$];
  int          mac_cyc[$];
  int          clr_cnt, fs_cnt, hold_bad, stall_left, done_cyc;
  logic        got_done, got_err;
  logic [31:0] got_loss;
  logic [31:0] cos_tab[4];
  int          block_at = -1;
  bit          spur_fin = 0;
  bit          busy_poke = 0;

  cos_loss_seq_ctrl #(.ADDR_W(16), .RD_LAT(2), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .cfg_log2_rows(cfg_log2_rows), .cfg_base(cfg_base), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mac_clr(mac_clr), .mac_en(mac_en), .fin_start(fin_start),
    .fin_done(fin_done), .fin_cos(fin_cos), .done(done), .err(err),
    .loss_out(loss_out), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // Drive one job and record its trace; everything is sampled at negedge.
  task automatic run_job(input logic [15:0] len, input logic [3:0] lg, input logic [15:0] base);
    int  fin_cnt, fin_row;
    bit  spur_done, poke_done;
    addr_log.delete(); issue_cyc.delete(); mac_cyc.delete();
    clr_cnt = 0; fs_cnt = 0; hold_bad = 0; stall_left = 5; done_cyc = -1;
    got_done = 0; got_err = 0; got_loss = 32'hDEAD_BEEF;
    fin_cnt = -1; fin_row = 0; spur_done = 0; poke_done = 0;
    @(negedge clk);
    start = 1; cfg_len = len; cfg_log2_rows = lg; cfg_base = base; mem_gnt = 1;
    @(negedge clk);
    cfg_len = 16'hFFFF; cfg_log2_rows = 4'hF; cfg_base = 16'hFFFF;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start = 0; fin_done = 0;
      if (done) begin
        got_done = 1; got_loss = loss_out; got_err = err; done_cyc = cyc;
        break;
      end
      if (mac_en) mac_cyc.push_back(cyc);
      if (mac_clr) clr_cnt++;
      if (fin_start) begin
        fs_cnt++; fin_cnt = 2;
      end else if (fin_cnt > 0) begin
        fin_cnt--;
      end else if (fin_cnt == 0) begin
        fin_done = 1; fin_cos = cos_tab[fin_row % 4]; fin_row++; fin_cnt = -1;
      end
      mem_gnt = 1;
      if (mem_req && block_at >= 0 && addr_log.size() == block_at && stall_left > 0) begin
        mem_gnt = 0; stall_left--;
        if (mem_addr !== base + 16'(block_at)) hold_bad++;
      end
      if (spur_fin && mem_req && !spur_done) begin
        fin_done = 1; fin_cos = 32'h1234_5678; spur_done = 1;
      end
      if (busy_poke && mem_req && !poke_done) begin
        start = 1; cfg_len = 16'd1; cfg_log2_rows = 4'd0; cfg_base = 16'h0BAD; poke_done = 1;
      end
      if (mem_req && mem_gnt) begin
        addr_log.push_back(mem_addr); issue_cyc.push_back(cyc);
      end
      @(negedge clk);
    end
    start = 0; mem_gnt = 0; fin_done = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; mem_gnt = 0; fin_done = 0; fin_cos = '0;
    cfg_len = '0; cfg_log2_rows = '0; cfg_base = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, mem_req, mac_clr, mac_en, fin_start, done, err} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 0000000", {busy, mem_req, mac_clr, mac_en, fin_start, done, err});
    end
    tests_run++;
    if (mem_addr !== 16'h0 || loss_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: addr %h loss %h want 0 0", mem_addr, loss_out);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    rst = 0;
  endtask

  task automatic test_single_row();
    int n_bad;
    cos_tab[0] = 32'h4000_0000;
    run_job(16'd4, 4'd0, 16'h0010);
    tests_run++;
    if (got_done !== 1'b1 || got_err !== 1'b0 || got_loss !== 32'h0) begin
      tests_failed++;
      $display("FAIL single_result: done %b err %b loss %h want 1 0 00000000", got_done, got_err, got_loss);
    end
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    n_bad = 0;
    foreach (exp_q[i]) if (i >= addr_log.size() || addr_log[i] !== exp_q[i]) n_bad++;
    tests_run++;
    if (addr_log.size() != exp_q.size() || n_bad != 0) begin
      tests_failed++;
      $display("FAIL single_addrs: %0d issued %0d wrong, want 4 issued 0 wrong", addr_log.size(), n_bad);
    end
    n_bad = 0;
    foreach (mac_cyc[i]) if (i >= issue_cyc.size() || mac_cyc[i] != issue_cyc[i] + 2) n_bad++;
    tests_run++;
    if (mac_cyc.size() != 4 || n_bad != 0) begin
      tests_failed++;
      $display("FAIL single_mac_en: %0d pulses %0d mistimed, want 4 pulses at issue+2", mac_cyc.size(), n_bad);
    end
    tests_run++;
    if (clr_cnt != 1 || fs_cnt != 1) begin
      tests_failed++;
      $display("FAIL single_clr_fin: clr %0d fin_start %0d want 1 1", clr_cnt, fs_cnt);
    end
    // CLR 1, ISSUE 4, DRAIN 3, FIN 4 (fin_done 3 cycles after fin_start), ACC 1 -> DONE at 13
    tests_run++;
    if (done_cyc != 13) begin
      tests_failed++;
      $display("FAIL single_latency: done at cycle %0d want 13", done_cyc);
    end
  endtask

  task automatic test_multi_row();
    int n_bad;
    // terms 0x4000_0000 + 0 + 0x8000_0000 + 0x2000_0000 = 0xE000_0000; /4 -> 0x3800_0000
    cos_tab = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'h2000_0000};
    run_job(16'd3, 4'd2, 16'h0100);
    tests_run++;
    if (got_done !== 1'b1 || got_err !== 1'b0 || got_loss !== 32'h3800_0000) begin
      tests_failed++;
      $display("FAIL multi_result: done %b err %b loss %h want 1 0 38000000", got_done, got_err, got_loss);
    end
    n_bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== 16'h0100 + 16'(i)) n_bad++;
    tests_run++;
    if (addr_log.size() != 12 || n_bad != 0) begin
      tests_failed++;
      $display("FAIL multi_addrs: %0d issued %0d wrong, want 12 contiguous", addr_log.size(), n_bad);
    end
    tests_run++;
    if (mac_cyc.size() != 12 || clr_cnt != 4 || fs_cnt != 4) begin
      tests_failed++;
      $display("FAIL multi_counts: mac %0d clr %0d fin_start %0d want 12 4 4", mac_cyc.size(), clr_cnt, fs_cnt);
    end
  endtask

  task automatic test_gnt_stall();
    int n_bad;
    cos_tab = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
    block_at = 2;
    run_job(16'd6, 4'd0, 16'h0020);
    block_at = -1;
    tests_run++;
    if (hold_bad != 0 || stall_left != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: bad addr cycles %0d stall cycles left %0d want 0 0", hold_bad, stall_left);
    end
    n_bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== 16'h0020 + 16'(i)) n_bad++;
    tests_run++;
    if (addr_log.size() != 6 || n_bad != 0 || mac_cyc.size() != 6) begin
      tests_failed++;
      $display("FAIL stall_counts: issued %0d wrong %0d mac %0d want 6 0 6", addr_log.size(), n_bad, mac_cyc.size());
    end
    tests_run++;
    if (got_done !== 1'b1 || got_loss !== 32'h2000_0000) begin
      tests_failed++;
      $display("FAIL stall_result: done %b loss %h want 1 20000000", got_done, got_loss);
    end
  endtask

  task automatic test_clamp();
    // 1.25 clamps to 1.0 -> term 0; -1.5 clamps to -1.0 -> term 0x8000_0000; /2
    cos_tab = '{32'h5000_0000, 32'hA000_0000, 32'h0, 32'h0};
    run_job(16'd2, 4'd1, 16'h0030);
    tests_run++;
    if (got_done !== 1'b1 || got_err !== 1'b0 || got_loss !== 32'h4000_0000) begin
      tests_failed++;
      $display("FAIL clamp_result: done %b err %b loss %h want 1 0 40000000", got_done, got_err, got_loss);
    end
  endtask

  task automatic test_len_zero();
    run_job(16'd0, 4'd3, 16'h0040);
    tests_run++;
    if (got_done !== 1'b1 || got_err !== 1'b1 || got_loss !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_result: done %b err %b loss %h want 1 1 00000000", got_done, got_err, got_loss);
    end
    tests_run++;
    if (addr_log.size() != 0 || done_cyc != 0) begin
      tests_failed++;
      $display("FAIL zero_timing: issued %0d done at %0d want 0 0", addr_log.size(), done_cyc);
    end
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_err_pulse: done %b err %b after done cycle want 0 0", done, err);
    end
  endtask

  task automatic test_spurious();
    // both rows cos 0 -> terms 0x4000_0000 each, sum 0x8000_0000, /2
    cos_tab = '{32'h0, 32'h0, 32'h0, 32'h0};
    spur_fin = 1; busy_poke = 1;
    run_job(16'd2, 4'd1, 16'h0050);
    spur_fin = 0; busy_poke = 0;
    tests_run++;
    if (got_done !== 1'b1 || got_loss !== 32'h4000_0000) begin
      tests_failed++;
      $display("FAIL spur_result: done %b loss %h want 1 40000000", got_done, got_loss);
    end
    tests_run++;
    if (addr_log.size() != 4 || mac_cyc.size() != 4 || fs_cnt != 2) begin
      tests_failed++;
      $display("FAIL spur_counts: issued %0d mac %0d fin_start %0d want 4 4 2", addr_log.size(), mac_cyc.size(), fs_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    cos_tab = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
    run_job(16'd4, 4'd0, 16'hFFFE);
    exp_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    tests_run++;
    if (addr_log.size() != 4 || addr_log[0] !== exp_q[0] || addr_log[1] !== exp_q[1]
        || addr_log[2] !== exp_q[2] || addr_log[3] !== exp_q[3]) begin
      tests_failed++;
      $display("FAIL wrap_addrs: %0d issued, third %h want 4 issued FFFE FFFF 0000 0001", addr_log.size(),
               (addr_log.size() > 2) ? addr_log[2] : 16'hxxxx);
    end
    tests_run++;
    if (got_done !== 1'b1 || got_loss !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_result: done %b loss %h want 1 0", got_done, got_loss);
    end
  endtask

  task automatic test_reset_mid_job();
    int late;
    @(negedge clk);
    start = 1; cfg_len = 16'd8; cfg_log2_rows = 4'd0; cfg_base = 16'h0060; mem_gnt = 1;
    @(negedge clk); start = 0;      // CLR
    @(negedge clk);                 // ISSUE, first read pending
    @(negedge clk);                 // first read in flight, second pending
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0061) begin
      tests_failed++;
      $display("FAIL midrst_setup: req %b addr %h want 1 0061", mem_req, mem_addr);
    end
    rst = 1;
    @(negedge clk);
    tests_run++;
    if ({busy, mem_req, mac_clr, mac_en, fin_start, done, err} !== 7'b0 || mem_addr !== 16'h0
        || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL midrst_outputs: flags %b addr %h state %0d want 0 0000 IDLE",
               {busy, mem_req, mac_clr, mac_en, fin_start, done, err}, mem_addr, dbg_state);
    end
    rst = 0;
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (mac_en || mem_req || busy) late++;
    end
    tests_run++;
    if (late != 0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: %0d active cycles after reset want 0", late);
    end
    cos_tab = '{32'h2000_0000, 32'h0, 32'h0, 32'h0};
    run_job(16'd4, 4'd0, 16'h0070);
    tests_run++;
    if (got_done !== 1'b1 || got_loss !== 32'h2000_0000 || addr_log.size() != 4 || mac_cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL midrst_rerun: done %b loss %h issued %0d mac %0d want 1 20000000 4 4",
               got_done, got_loss, addr_log.size(), mac_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_multi_row();
    test_gnt_stall();
    test_clamp();
    test_len_zero();
    test_spurious();
    test_addr_wrap();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
